// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      REFILL,
      RESPOND
   } state_t;

   function automatic int word_bits(input int words);
      return $clog2(words);
   endfunction

   function automatic int index_bits(input int lines);
      return $clog2(lines);
   endfunction

   // Tag takes whatever is left above byte offset, word select and index.
   function automatic int tag_bits(input int w, input int lines, input int words);
      return w - 2 - $clog2(lines) - $clog2(words);
   endfunction

endpackage

// File: rtl/icache_ram.sv
// Cache data array: synchronous write, asynchronous read, addressed by line and word.
module icache_ram
   import icache_pkg::*;
#(
   parameter int W     = 32,
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [index_bits(LINES)-1:0] line,
   input  logic [word_bits(WORDS)-1:0]  wr_word,
   input  logic [W-1:0]                 wdata,
   input  logic [word_bits(WORDS)-1:0]  rd_word,
   output logic [W-1:0]                 rdata
);

   logic [W-1:0] mem [LINES*WORDS];

   // NOTE: the data array has no reset; the per-line valid bits in the top guard stale contents.
   always_ff @(posedge clk) begin
      if (we) mem[{line, wr_word}] <= wdata;
   end

   assign rdata = mem[{line, rd_word}];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache with line refill over a single-word memory bus.
// Define ICACHE_STATS_EN to add the hit_cnt/miss_cnt lookup counters.
module icache_fetch
   import icache_pkg::*;
#(
   parameter int W     = 32,
   parameter int LINES = 16,
   parameter int WORDS = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         cpu_req,
   input  logic [W-1:0] cpu_adr,
   output logic         cpu_ack,
   output logic [W-1:0] cpu_instr,
   input  logic         flush,
   output logic         mem_req,
   output logic [W-1:0] mem_adr,
   input  logic [W-1:0] mem_rdata,
   input  logic         mem_valid
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]  hit_cnt,
   output logic [31:0]  miss_cnt
`endif
);

   localparam int WB  = word_bits(WORDS);
   localparam int IB  = index_bits(LINES);
   localparam int TGB = tag_bits(W, LINES, WORDS);

   state_t           state, state_nx;
   logic [W-3:0]     adr_q;         // captured word address
   logic [WB-1:0]    beat, beat_nx;
   logic [TGB-1:0]   tag_arr [LINES];
   logic [LINES-1:0] valid;
   logic             flush_seen;

   logic [WB-1:0]    adr_word;
   logic [IB-1:0]    adr_index;
   logic [TGB-1:0]   adr_tag;
   logic [W-1:0]     ram_rdata;
   logic             hit, last_beat;
   logic             capture, miss_start, ram_we, fill_done, ack_nx;
   logic             unused_adr_lsbs;

   assign adr_word        = adr_q[WB-1:0];
   assign adr_index       = adr_q[IB+WB-1:WB];
   assign adr_tag         = adr_q[W-3:IB+WB];
   assign unused_adr_lsbs = ^cpu_adr[1:0];

   assign hit       = valid[adr_index] && (tag_arr[adr_index] == adr_tag);
   assign last_beat = (beat == WB'(WORDS - 1));
   assign beat_nx   = beat + WB'(1);

   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (cpu_req) state_nx = LOOKUP;
         LOOKUP:  state_nx = hit ? IDLE : REFILL;
         REFILL:  if (mem_valid && last_beat) state_nx = RESPOND;
         RESPOND: state_nx = IDLE;
      endcase
   end

   always_comb begin
      capture    = 1'b0;
      miss_start = 1'b0;
      ram_we     = 1'b0;
      ack_nx     = 1'b0;
      unique case (state)
         IDLE:    capture    = cpu_req;
         LOOKUP:  begin
            ack_nx     = hit;
            miss_start = !hit;
         end
         REFILL:  ram_we     = mem_valid && reset;
         RESPOND: ack_nx     = 1'b1;
      endcase
      fill_done = ram_we && last_beat;
   end

   icache_ram #(
      .W     (W),
      .LINES (LINES),
      .WORDS (WORDS)
   ) u_ram (
      .clk     (clk),
      .we      (ram_we),
      .line    (adr_index),
      .wr_word (beat),
      .wdata   (mem_rdata),
      .rd_word (adr_word),
      .rdata   (ram_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset) begin
         cpu_ack    <= 1'b0;
         cpu_instr  <= '0;
         mem_req    <= 1'b0;
         mem_adr    <= '0;
         beat       <= '0;
         valid      <= '0;
         flush_seen <= 1'b0;
      end else begin
         cpu_ack <= ack_nx;
         if (ack_nx) cpu_instr <= ram_rdata;

         if (miss_start) begin
            mem_req    <= 1'b1;
            mem_adr    <= {adr_q[W-3:WB], {WB{1'b0}}, 2'b00};
            beat       <= '0;
            flush_seen <= 1'b0;
         end else if (ram_we) begin
            beat    <= beat_nx;
            mem_adr <= {adr_q[W-3:WB], beat_nx, 2'b00};
            if (last_beat) mem_req <= 1'b0;
         end

         if (state == REFILL && flush) flush_seen <= 1'b1;

         // A flush anywhere in the refill, including the final beat, keeps the line invalid.
         if (flush)                          valid            <= '0;
         else if (fill_done && !flush_seen) valid[adr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (capture)   adr_q              <= cpu_adr[W-1:2];
      if (fill_done) tag_arr[adr_index] <= adr_tag;
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else if (state == LOOKUP) begin
         if (hit) hit_cnt  <= hit_cnt + 32'd1;
         else     miss_cnt <= miss_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: refill order, hit latency, conflicts, flush, stalls, reset abort.
module tb_icache_fetch;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_req;
   logic [W-1:0] cpu_adr;
   logic         cpu_ack;
   logic [W-1:0] cpu_instr;
   logic         flush;
   logic         mem_req;
   logic [W-1:0] mem_adr;
   logic [W-1:0] mem_rdata;
   logic         mem_valid;
`ifdef ICACHE_STATS_EN
   logic [31:0]  hit_cnt;
   logic [31:0]  miss_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   icache_fetch #(.W(W), .LINES(16), .WORDS(4)) dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_adr   (cpu_adr),
      .cpu_ack   (cpu_ack),
      .cpu_instr (cpu_instr),
      .flush     (flush),
      .mem_req   (mem_req),
      .mem_adr   (mem_adr),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid)
`ifdef ICACHE_STATS_EN
      ,
      .hit_cnt   (hit_cnt),
      .miss_cnt  (miss_cnt)
`endif
   );

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Memory content model: each word carries its own address in the low half.
   function automatic logic [W-1:0] mem_data(input logic [W-1:0] a);
      return 32'hC0DE_0000 | a;
   endfunction

   // Request is presented for one sample edge, then the address bus is scrambled.
   task automatic fetch_issue(input string tag, input logic [W-1:0] addr);
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_adr = addr;
      @(negedge clk);
      cpu_req = 1'b0;
      cpu_adr = 32'hDEAD_BEEF;
      check({tag, "_no_early_ack"}, cpu_ack, 1'b0);
   endtask

   task automatic fetch_hit(input string tag, input logic [W-1:0] addr,
                            input logic [W-1:0] exp, input bit flush_in_lookup);
      fetch_issue(tag, addr);
      if (flush_in_lookup) flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check({tag, "_ack"}, cpu_ack, 1'b1);
      check({tag, "_instr"}, cpu_instr, exp);
      check({tag, "_no_mem_req"}, mem_req, 1'b0);
   endtask

   task automatic fetch_miss(input string tag, input logic [W-1:0] addr, input logic [W-1:0] exp,
                             input int stall, input int flush_beat);
      logic [W-1:0] base;
      logic [W-1:0] beat_adr;
      bit           hold_ok;
      base = addr & ~32'hF;
      fetch_issue(tag, addr);
      @(negedge clk);
      check({tag, "_mem_req"}, mem_req, 1'b1);
      for (int b = 0; b < 4; b++) begin
         beat_adr = base + W'(4 * b);
         hold_ok  = 1'b1;
         for (int s = 0; s < stall; s++) begin
            if (mem_req !== 1'b1 || mem_adr !== beat_adr || cpu_ack !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
         end
         if (stall > 0) check({tag, "_stall_hold"}, hold_ok, 1'b1);
         check({tag, "_mem_adr"}, mem_adr, beat_adr);
         mem_valid = 1'b1;
         mem_rdata = mem_data(beat_adr);
         if (b == flush_beat) flush = 1'b1;
         @(negedge clk);
         mem_valid = 1'b0;
         flush     = 1'b0;
      end
      check({tag, "_req_dropped"}, mem_req, 1'b0);
      check({tag, "_ack_wait"}, cpu_ack, 1'b0);
      @(negedge clk);
      check({tag, "_ack"}, cpu_ack, 1'b1);
      check({tag, "_instr"}, cpu_instr, exp);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b0;
      cpu_req   = 1'b0;
      cpu_adr   = '0;
      flush     = 1'b0;
      mem_rdata = '0;
      mem_valid = 1'b1;   // stray valid while idle must be ignored
      repeat (3) @(negedge clk);
      check("rst_ack", cpu_ack, 1'b0);
      check("rst_instr", cpu_instr, 32'h0);
      check("rst_mem_req", mem_req, 1'b0);
      check("rst_mem_adr", mem_adr, 32'h0);
      reset = 1'b1;
      @(negedge clk);
      mem_valid = 1'b0;
      check("idle_mem_req", mem_req, 1'b0);
`ifdef ICACHE_STATS_EN
      check("rst_hit_cnt", hit_cnt, 32'd0);
      check("rst_miss_cnt", miss_cnt, 32'd0);
`endif

      fetch_miss("cold_48", 32'h0000_0048, 32'hC0DE_0048, 0, -1);
      fetch_hit("hit_4c", 32'h0000_004C, 32'hC0DE_004C, 1'b0);
      fetch_hit("hit_40", 32'h0000_0040, 32'hC0DE_0040, 1'b0);
      fetch_miss("conflict_448", 32'h0000_0448, 32'hC0DE_0448, 0, -1);
      fetch_miss("evicted_48", 32'h0000_0048, 32'hC0DE_0048, 0, -1);

      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      fetch_miss("post_flush_48", 32'h0000_0048, 32'hC0DE_0048, 0, -1);
      fetch_hit("hit_44", 32'h0000_0044, 32'hC0DE_0044, 1'b0);

      fetch_miss("flush_b2_448", 32'h0000_0448, 32'hC0DE_0448, 0, 2);
      fetch_miss("after_flush_b2", 32'h0000_0448, 32'hC0DE_0448, 0, -1);
      fetch_hit("flush_lookup_44c", 32'h0000_044C, 32'hC0DE_044C, 1'b1);
      fetch_miss("after_flush_lookup", 32'h0000_044C, 32'hC0DE_044C, 0, -1);

      fetch_miss("stall_84", 32'h0000_0084, 32'hC0DE_0084, 20, -1);
      fetch_hit("hit_88", 32'h0000_0088, 32'hC0DE_0088, 1'b0);
`ifdef ICACHE_STATS_EN
      check("pre_rst_hit_cnt", hit_cnt, 32'd5);
      check("pre_rst_miss_cnt", miss_cnt, 32'd8);
`endif

      // Abort a refill of 0x48 after two beats; late data must not complete it.
      fetch_issue("abort_48", 32'h0000_0048);
      @(negedge clk);
      for (int b = 0; b < 2; b++) begin
         mem_valid = 1'b1;
         mem_rdata = mem_data(32'h40 + W'(4 * b));
         @(negedge clk);
      end
      reset     = 1'b0;
      mem_rdata = mem_data(32'h48);
      @(negedge clk);
      check("abort_mem_req", mem_req, 1'b0);
      check("abort_ack", cpu_ack, 1'b0);
      check("abort_mem_adr", mem_adr, 32'h0);
`ifdef ICACHE_STATS_EN
      check("abort_hit_cnt", hit_cnt, 32'd0);
      check("abort_miss_cnt", miss_cnt, 32'd0);
`endif
      reset = 1'b1;
      @(negedge clk);
      check("late_valid_mem_req", mem_req, 1'b0);
      check("late_valid_ack", cpu_ack, 1'b0);
      mem_valid = 1'b0;

      fetch_miss("post_rst_88", 32'h0000_0088, 32'hC0DE_0088, 0, -1);
      fetch_miss("post_rst_48", 32'h0000_0048, 32'hC0DE_0048, 0, -1);
      fetch_hit("post_rst_hit_4c", 32'h0000_004C, 32'hC0DE_004C, 1'b0);
`ifdef ICACHE_STATS_EN
      check("end_hit_cnt", hit_cnt, 32'd1);
      check("end_miss_cnt", miss_cnt, 32'd2);
`endif

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
